isdft_synth: RTL and testbench
==============================

Name: isdft_synth

Overview:
- Inverse companion to the sliding DFT core. Consumes the per-sample bin stream the sdft emits: N complex bins per sample tick, framed by sob/eob/valid.
- Applies a per-bin real gain read from an external gain memory, then reconstructs one time-domain sample per frame: sum of gain-weighted real parts divided by N.
- Sits after sdft (and any spectral processing) to close the analysis/synthesis loop.
- Input bins must be un-windowed (HANNING_EN=0 upstream).

Parameters:
- N, 16, bins per frame; power of 2, >=2
- DW, 16, output sample width, signed
- IW, 26, width of each RE/IM input component, signed
- GW, 10, gain width; unsigned Q1.(GW-1), so 1.0 = 2**(GW-1)

Ports:
- clk_i  in  1  clock
- srst_i  in  1  synchronous reset, active-high
- data_i  in  2*IW  packed bin {IM,RE}; RE = [IW-1:0], IM ignored
- valid_i  in  1  bin beat valid
- sob_i  in  1  first bin of frame, qualified by valid_i
- eob_i  in  1  last bin of frame, qualified by valid_i
- gainaddr_o  out  $clog2(N)  gain memory read address, combinational
- gain_i  in  GW  gain memory data, valid 1 cycle after gainaddr_o
- data_o  out  DW  reconstructed sample, signed
- valid_o  out  1  one-cycle pulse per good frame
- frame_err_o  out  1  one-cycle pulse on framing violation

Behaviour:
- Reset: data_o=0, valid_o=0, frame_err_o=0, state=IDLE, bin counter=0, accumulator=0, pipeline valid flags cleared. Reset mid-frame discards the partial frame; no valid_o is emitted for it.
- gainaddr_o = sob_i ? 0 : bin_cnt (combinational). Beats may be non-contiguous; gaps hold all state.
- Input FSM, evaluated on valid_i beats:
  - IDLE:
    - sob_i -> ACC, bin_cnt=1; if eob_i also set (N must be 1, which is illegal), error.
    - Beat without sob_i -> frame_err_o, beat dropped, stay IDLE.
  - ACC:
    - sob_i -> frame_err_o, old frame killed, new frame starts, bin_cnt=1.
    - eob_i with bin_cnt==N-1 -> frame good, IDLE.
    - eob_i with bin_cnt!=N-1 -> frame_err_o, drop, IDLE.
    - bin_cnt==N-1 without eob_i -> frame_err_o, drop, IDLE.
    - Otherwise bin_cnt++.
  - frame_err_o is asserted the cycle after the offending beat.
- Pipeline:
  - S1 (t+1): register RE, first/last/kill flags; gain_i sampled here.
  - S2 (t+2): product = RE * $signed({1'b0,gain_i}), width IW+GW+1.
  - S3 (t+3): first-bin beat loads the accumulator, others add to it. Accumulator width IW+GW+1+$clog2(N), so it never overflows.
- Output: on the last-bin beat at S3, final = acc + product, shifted arithmetically right by $clog2(N)+GW-1.
  - Result saturates to [-2**(DW-1), 2**(DW-1)-1].
  - data_o registered, valid_o high for one cycle. Latency from eob beat to valid_o = 3 clocks.
  - data_o holds its value between frames.
- Killed frames never assert valid_o. A kill coinciding with a good eob in flight does not corrupt the in-flight frame; flags travel with each beat.
- Back-to-back frames (sob on the cycle after eob) are fully supported at 1 beat/clock.

Optional Feature:
- Macro ISDFT_SYNTH_ROUND_EN.
- Defined: add 2**(shift-1) to final before the arithmetic shift (round half up), then saturate.
- Undefined: plain arithmetic shift (floor).

Test Plan:
- N=16, all RE=1000, gain=512 (1.0), contiguous -> data_o=1000, valid_o 3 clocks after eob; 10 back-to-back frames -> 10 pulses, no gaps.
- Gain memory bins 0..7=512, 8..15=0; RE=1600 all -> data_o=800. Also check gainaddr_o sequence 0..15.
- All RE=2**20, gain 1.0 -> data_o=32767; all RE=-2**20 -> -32768.
- Bin 0 RE=24, rest 0, gain 1.0 -> data_o=1 without macro, 2 with ISDFT_SYNTH_ROUND_EN; RE=-24 -> -2 / -1 respectively.
- eob on 10th beat -> frame_err_o one pulse, no valid_o. Next good frame -> correct output. Beat without sob in IDLE -> frame_err_o.
- srst_i pulsed at bin 7 -> outputs 0, no valid_o; following frame with RE=1000 -> data_o=1000.

Source files
------------

// File: rtl/isdft_synth.sv
// rtl/isdft_synth.sv - inverse sliding-DFT synthesis: gain-weighted sum of bin real parts / N per frame
// Define ISDFT_SYNTH_ROUND_EN for round-half-up output scaling instead of floor.
module isdft_synth #(
  parameter int N  = 16,
  parameter int DW = 16,
  parameter int IW = 26,
  parameter int GW = 10
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic [2*IW-1:0]      data_i,
  input  logic                 valid_i,
  input  logic                 sob_i,
  input  logic                 eob_i,
  output logic [$clog2(N)-1:0] gainaddr_o,
  input  logic [GW-1:0]        gain_i,
  output logic [DW-1:0]        data_o,
  output logic                 valid_o,
  output logic                 frame_err_o
);
  localparam int CW = $clog2(N);
  localparam int PW = IW + GW + 1;
  localparam int AW = PW + CW;
  localparam int SH = CW + GW - 1;
  localparam logic [CW-1:0]        LAST_BIN = CW'(N - 1);
  localparam logic signed [AW-1:0] SAT_MAX  = AW'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] SAT_MIN  = AW'(-(64'sd1 <<< (DW - 1)));
`ifdef ISDFT_SYNTH_ROUND_EN
  localparam logic signed [AW-1:0] RND      = AW'(64'sd1 <<< (SH - 1));
`endif

  typedef enum logic {IDLE, ACC} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] bin_cnt_q, bin_cnt_d;
  logic          beat_take, beat_first, beat_last, beat_kill, beat_err;

  logic                 s1_vld_q, s1_vld_d, s1_first_q, s1_first_d;
  logic                 s1_last_q, s1_last_d, s1_kill_q, s1_kill_d;
  logic signed [IW-1:0] s1_re_q, s1_re_d;
  logic                 s2_vld_q, s2_vld_d, s2_first_q, s2_first_d;
  logic                 s2_last_q, s2_last_d, s2_kill_q, s2_kill_d;
  logic signed [PW-1:0] s2_prod_q, s2_prod_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] acc_base, acc_sum, fin, res;
  logic [DW-1:0]        data_q, data_d;
  logic                 valid_q, valid_d, err_q, err_d;

  logic unused_im;
  assign unused_im = ^data_i[2*IW-1:IW];

  assign gainaddr_o = sob_i ? '0 : bin_cnt_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= IDLE;
      bin_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bin_cnt_q <= bin_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_cnt_d = bin_cnt_q;
    if (valid_i) begin
      if (sob_i) begin
        // sob always restarts framing; sob together with eob can never form a legal frame
        state_d   = eob_i ? IDLE : ACC;
        bin_cnt_d = eob_i ? '0 : CW'(1);
      end else if (state_q == ACC) begin
        if (eob_i || (bin_cnt_q == LAST_BIN)) begin
          state_d   = IDLE;
          bin_cnt_d = '0;
        end else begin
          bin_cnt_d = bin_cnt_q + CW'(1);
        end
      end
    end
  end

  always_comb begin
    beat_take  = 1'b0;
    beat_first = 1'b0;
    beat_last  = 1'b0;
    beat_kill  = 1'b0;
    beat_err   = 1'b0;
    if (valid_i) begin
      if (sob_i) begin
        beat_take  = !eob_i;
        beat_first = !eob_i;
        beat_kill  = eob_i;
        beat_err   = eob_i || (state_q == ACC);
      end else if (state_q == IDLE) begin
        beat_err = 1'b1;
      end else if (eob_i && (bin_cnt_q == LAST_BIN)) begin
        beat_take = 1'b1;
        beat_last = 1'b1;
      end else if (eob_i || (bin_cnt_q == LAST_BIN)) begin
        beat_err  = 1'b1;
        beat_kill = 1'b1;
      end else begin
        beat_take = 1'b1;
      end
    end
  end

  // Flags ride with each beat so a kill behind a good eob cannot disturb it
  always_comb begin
    s1_vld_d   = beat_take | beat_kill;
    s1_first_d = beat_first;
    s1_last_d  = beat_last;
    s1_kill_d  = beat_kill;
    s1_re_d    = s1_vld_d ? $signed(data_i[IW-1:0]) : s1_re_q;

    s2_vld_d   = s1_vld_q;
    s2_first_d = s1_first_q;
    s2_last_d  = s1_last_q;
    s2_kill_d  = s1_kill_q;
    s2_prod_d  = s1_vld_q ? PW'(s1_re_q) * PW'($signed({1'b0, gain_i})) : s2_prod_q;

    acc_base = s2_first_q ? '0 : acc_q;
    acc_sum  = acc_base + AW'(s2_prod_q);
    fin      = acc_sum;
`ifdef ISDFT_SYNTH_ROUND_EN
    fin      = acc_sum + RND;
`endif
    res      = fin >>> SH;

    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = beat_err;
    if (s2_vld_q) begin
      acc_d = s2_kill_q ? '0 : acc_sum;
      if (s2_last_q) begin
        valid_d = 1'b1;
        if (res > SAT_MAX) begin
          data_d = DW'(SAT_MAX);
        end else if (res < SAT_MIN) begin
          data_d = DW'(SAT_MIN);
        end else begin
          data_d = DW'(res);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_kill_q  <= 1'b0;
      s1_re_q    <= '0;
      s2_vld_q   <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_kill_q  <= 1'b0;
      s2_prod_q  <= '0;
      acc_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s1_kill_q  <= s1_kill_d;
      s1_re_q    <= s1_re_d;
      s2_vld_q   <= s2_vld_d;
      s2_first_q <= s2_first_d;
      s2_last_q  <= s2_last_d;
      s2_kill_q  <= s2_kill_d;
      s2_prod_q  <= s2_prod_d;
      acc_q      <= acc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = err_q;

endmodule

// File: tb/tb_isdft_synth.sv
// tb/tb_isdft_synth.sv - self-checking bench for isdft_synth against a frame-level arithmetic model
module tb_isdft_synth;
  localparam int N  = 16;
  localparam int DW = 16;
  localparam int IW = 26;
  localparam int GW = 10;
  localparam int CW = $clog2(N);

  logic          clk = 1'b0;
  logic          srst;
  logic [2*IW-1:0] data_i;
  logic          valid_i, sob_i, eob_i;
  logic [CW-1:0] gainaddr_o;
  logic [GW-1:0] gain_i;
  logic [DW-1:0] data_o;
  logic          valid_o, frame_err_o;

  isdft_synth #(.N(N), .DW(DW), .IW(IW), .GW(GW)) dut (
    .clk_i(clk), .srst_i(srst), .data_i(data_i), .valid_i(valid_i),
    .sob_i(sob_i), .eob_i(eob_i), .gainaddr_o(gainaddr_o), .gain_i(gain_i),
    .data_o(data_o), .valid_o(valid_o), .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [GW-1:0] gain_mem [N];
  always @(posedge clk) gain_i <= gain_mem[gainaddr_o];

  int got_val[$], got_cyc[$], got_err[$];
  int exp_val[$], exp_cyc[$];
  int re_buf[N];
  int n_cmp = 0, n_fail = 0;

  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      got_val.push_back(int'($signed(data_o)));
      got_cyc.push_back(cyc);
    end
    if (frame_err_o === 1'b1) got_err.push_back(cyc);
  end

  // Expected sample = floor (or round-half-up) of sum(RE*gain) / (N * unity gain), saturated
  function automatic int model_out();
    longint s = 0;
    longint d = longint'(N) * (longint'(1) << (GW - 1));
    longint q;
    longint hi = (longint'(1) << (DW - 1)) - 1;
    for (int k = 0; k < N; k++) s += longint'(re_buf[k]) * longint'(gain_mem[k]);
`ifdef ISDFT_SYNTH_ROUND_EN
    s += d / 2;
`endif
    q = s / d;
    if (q * d > s) q -= 1;
    if (q > hi) q = hi;
    else if (q < -hi - 1) q = -hi - 1;
    return int'(q);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      valid_i = 1'b0;
      sob_i   = 1'($urandom);
      eob_i   = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_beat(input int re, input bit sob, input bit eob, output int bcyc, output int ga);
    data_i  = {IW'($urandom), IW'(re)};
    valid_i = 1'b1;
    sob_i   = sob;
    eob_i   = eob;
    bcyc    = cyc;
    #1;
    ga = int'(gainaddr_o);
    @(posedge clk); #1;
    valid_i = 1'b0;
    sob_i   = 1'b0;
    eob_i   = 1'b0;
  endtask

  task automatic send_frame(input int gapmax);
    int bc, ga;
    for (int k = 0; k < N; k++) begin
      if (k > 0 && gapmax > 0) idle(int'($urandom_range(gapmax, 0)));
      drive_beat(re_buf[k], k == 0, k == N - 1, bc, ga);
    end
    exp_val.push_back(model_out());
    exp_cyc.push_back(bc + 3);
  endtask

  task automatic flush();
    idle(8);
    got_val.delete(); got_cyc.delete(); got_err.delete();
    exp_val.delete(); exp_cyc.delete();
  endtask

  task automatic test_reset();
    srst = 1'b1; valid_i = 1'b0; sob_i = 1'b0; eob_i = 1'b0; data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (data_o !== '0) begin n_fail++; $display("FAIL reset.data_o got %0h want 0", data_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset.valid_o got %b want 0", valid_o); end
    n_cmp++; if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL reset.frame_err_o got %b want 0", frame_err_o); end
    n_cmp++; if (gainaddr_o !== '0) begin n_fail++; $display("FAIL reset.gainaddr_o got %0d want 0", gainaddr_o); end
    srst = 1'b0;
  endtask

  task automatic test_unity_back_to_back();
    flush();
    for (int k = 0; k < N; k++) begin gain_mem[k] = GW'(512); re_buf[k] = 1000; end
    repeat (10) send_frame(0);
    idle(6);
    n_cmp++; if (got_val.size() != 10) begin n_fail++; $display("FAIL b2b.count got %0d want 10", got_val.size()); end
    for (int i = 0; i < got_val.size() && i < exp_val.size(); i++) begin
      n_cmp++; if (got_val[i] !== 1000) begin n_fail++; $display("FAIL b2b.data[%0d] got %0d want 1000", i, got_val[i]); end
      n_cmp++; if (got_cyc[i] !== exp_cyc[i]) begin n_fail++; $display("FAIL b2b.cycle[%0d] got %0d want %0d", i, got_cyc[i], exp_cyc[i]); end
    end
    n_cmp++; if (got_err.size() != 0) begin n_fail++; $display("FAIL b2b.err_count got %0d want 0", got_err.size()); end
  endtask

  task automatic test_half_gain();
    int bc, ga;
    flush();
    for (int k = 0; k < N; k++) begin gain_mem[k] = (k < 8) ? GW'(512) : GW'(0); re_buf[k] = 1600; end
    for (int k = 0; k < N; k++) begin
      drive_beat(re_buf[k], k == 0, k == N - 1, bc, ga);
      n_cmp++; if (ga !== k) begin n_fail++; $display("FAIL half.gainaddr[%0d] got %0d want %0d", k, ga, k); end
    end
    idle(6);
    n_cmp++; if (got_val.size() != 1) begin n_fail++; $display("FAIL half.count got %0d want 1", got_val.size()); end
    if (got_val.size() > 0) begin
      n_cmp++; if (got_val[0] !== 800) begin n_fail++; $display("FAIL half.data got %0d want 800", got_val[0]); end
      n_cmp++; if (got_cyc[0] !== bc + 3) begin n_fail++; $display("FAIL half.cycle got %0d want %0d", got_cyc[0], bc + 3); end
    end
  endtask

  task automatic test_saturation();
    flush();
    for (int k = 0; k < N; k++) begin gain_mem[k] = GW'(512); re_buf[k] = 1 << 20; end
    send_frame(1);
    for (int k = 0; k < N; k++) re_buf[k] = -(1 << 20);
    send_frame(0);
    idle(6);
    n_cmp++; if (got_val.size() != 2) begin n_fail++; $display("FAIL sat.count got %0d want 2", got_val.size()); end
    if (got_val.size() == 2) begin
      n_cmp++; if (got_val[0] !== 32767) begin n_fail++; $display("FAIL sat.pos got %0d want 32767", got_val[0]); end
      n_cmp++; if (got_val[1] !== -32768) begin n_fail++; $display("FAIL sat.neg got %0d want -32768", got_val[1]); end
      n_cmp++; if (got_cyc[1] !== exp_cyc[1]) begin n_fail++; $display("FAIL sat.cycle got %0d want %0d", got_cyc[1], exp_cyc[1]); end
    end
  endtask

  task automatic test_rounding();
    int want_p, want_n;
`ifdef ISDFT_SYNTH_ROUND_EN
    want_p = 2;  want_n = -1;
`else
    want_p = 1;  want_n = -2;
`endif
    flush();
    for (int k = 0; k < N; k++) begin gain_mem[k] = GW'(512); re_buf[k] = 0; end
    re_buf[0] = 24;
    send_frame(0);
    re_buf[0] = -24;
    send_frame(2);
    idle(6);
    n_cmp++; if (got_val.size() != 2) begin n_fail++; $display("FAIL round.count got %0d want 2", got_val.size()); end
    if (got_val.size() == 2) begin
      n_cmp++; if (got_val[0] !== want_p) begin n_fail++; $display("FAIL round.pos got %0d want %0d", got_val[0], want_p); end
      n_cmp++; if (got_val[1] !== want_n) begin n_fail++; $display("FAIL round.neg got %0d want %0d", got_val[1], want_n); end
    end
  endtask

  task automatic test_frame_err();
    int bc, ga;
    int e_err[$];
    flush();
    for (int k = 0; k < N; k++) begin gain_mem[k] = GW'(512); re_buf[k] = 1000; end
    for (int k = 0; k < 10; k++) drive_beat(1000, k == 0, k == 9, bc, ga);
    e_err.push_back(bc + 1);
    idle(2);
    send_frame(0);
    drive_beat(1000, 1'b0, 1'b0, bc, ga);
    e_err.push_back(bc + 1);
    for (int k = 0; k < 5; k++) drive_beat(5000, k == 0, 1'b0, bc, ga);
    e_err.push_back(bc + 2);
    send_frame(0);
    for (int k = 0; k < N; k++) drive_beat(1000, k == 0, 1'b0, bc, ga);
    e_err.push_back(bc + 1);
    send_frame(1);
    idle(6);
    n_cmp++; if (got_err.size() != e_err.size()) begin n_fail++; $display("FAIL ferr.err_count got %0d want %0d", got_err.size(), e_err.size()); end
    for (int i = 0; i < got_err.size() && i < e_err.size(); i++) begin
      n_cmp++; if (got_err[i] !== e_err[i]) begin n_fail++; $display("FAIL ferr.err_cycle[%0d] got %0d want %0d", i, got_err[i], e_err[i]); end
    end
    n_cmp++; if (got_val.size() != 3) begin n_fail++; $display("FAIL ferr.count got %0d want 3", got_val.size()); end
    for (int i = 0; i < got_val.size() && i < exp_val.size(); i++) begin
      n_cmp++; if (got_val[i] !== 1000) begin n_fail++; $display("FAIL ferr.data[%0d] got %0d want 1000", i, got_val[i]); end
      n_cmp++; if (got_cyc[i] !== exp_cyc[i]) begin n_fail++; $display("FAIL ferr.cycle[%0d] got %0d want %0d", i, got_cyc[i], exp_cyc[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int bc, ga;
    flush();
    for (int k = 0; k < N; k++) begin gain_mem[k] = GW'(512); re_buf[k] = 1000; end
    for (int k = 0; k < 7; k++) drive_beat(3000, k == 0, 1'b0, bc, ga);
    srst = 1'b1;
    idle(1);
    n_cmp++; if (data_o !== '0) begin n_fail++; $display("FAIL rstmid.data_o got %0h want 0", data_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid.valid_o got %b want 0", valid_o); end
    srst = 1'b0;
    idle(5);
    n_cmp++; if (got_val.size() != 0) begin n_fail++; $display("FAIL rstmid.no_valid got %0d want 0", got_val.size()); end
    send_frame(0);
    idle(6);
    n_cmp++; if (got_val.size() != 1) begin n_fail++; $display("FAIL rstmid.count got %0d want 1", got_val.size()); end
    if (got_val.size() == 1) begin
      n_cmp++; if (got_val[0] !== 1000) begin n_fail++; $display("FAIL rstmid.data got %0d want 1000", got_val[0]); end
      n_cmp++; if (got_cyc[0] !== exp_cyc[0]) begin n_fail++; $display("FAIL rstmid.cycle got %0d want %0d", got_cyc[0], exp_cyc[0]); end
    end
    n_cmp++; if (got_err.size() != 0) begin n_fail++; $display("FAIL rstmid.err_count got %0d want 0", got_err.size()); end
  endtask

  task automatic test_random();
    flush();
    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < N; k++) begin
        gain_mem[k] = GW'($urandom_range((1 << GW) - 1, 0));
        if (f % 2 == 0) re_buf[k] = int'($urandom_range(65535, 0)) - 32768;
        else re_buf[k] = int'($urandom_range((1 << IW) - 1, 0)) - (1 << (IW - 1));
      end
      send_frame(2);
      idle(int'($urandom_range(3, 0)));
    end
    idle(6);
    n_cmp++; if (got_val.size() != exp_val.size()) begin n_fail++; $display("FAIL rand.count got %0d want %0d", got_val.size(), exp_val.size()); end
    for (int i = 0; i < got_val.size() && i < exp_val.size(); i++) begin
      n_cmp++; if (got_val[i] !== exp_val[i]) begin n_fail++; $display("FAIL rand.data[%0d] got %0d want %0d", i, got_val[i], exp_val[i]); end
      n_cmp++; if (got_cyc[i] !== exp_cyc[i]) begin n_fail++; $display("FAIL rand.cycle[%0d] got %0d want %0d", i, got_cyc[i], exp_cyc[i]); end
    end
    n_cmp++; if (got_err.size() != 0) begin n_fail++; $display("FAIL rand.err_count got %0d want 0", got_err.size()); end
  endtask

  initial begin
    srst = 1'b1; valid_i = 1'b0; sob_i = 1'b0; eob_i = 1'b0; data_i = '0;
    for (int k = 0; k < N; k++) gain_mem[k] = GW'(512);
    #1;
    test_reset();
    test_unity_back_to_back();
    test_half_gain();
    test_saturation();
    test_rounding();
    test_frame_err();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
